// File: rtl/tpu_mem_loader.sv
// Packs a serial word stream into NUM_UNITS-lane write beats for the TPU's
// image (mem1), kernel (mem2) and simple memories, one strobe per beat.
module tpu_mem_loader #(
  parameter int  DATA_WIDTH   = 16,
  parameter int  IMAGE_WIDTH  = 5,
  parameter int  IMAGE_HEIGHT = 5,
  parameter int  NUM_UNITS    = 9,
  localparam int MEM_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int AW           = $clog2(MEM_SIZE),
  localparam int CW           = $clog2(MEM_SIZE + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic [1:0]                      i_cmd_target,
  input  logic [AW-1:0]                   i_cmd_base_addr,
  input  logic [CW-1:0]                   i_cmd_count,
  input  logic                            i_s_valid,
  output logic                            o_s_ready,
  input  logic [DATA_WIDTH-1:0]           i_s_data,
  output logic [NUM_UNITS*DATA_WIDTH-1:0] o_data_in,
  output logic [NUM_UNITS*AW-1:0]         o_wr_addr,
  output logic                            o_write_mem1,
  output logic                            o_write_mem2,
  output logic                            o_simple_write,
  output logic                            o_busy,
  output logic                            o_cmd_done,
  output logic                            o_cmd_error
);
  localparam int LW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int SW = ((AW > CW) ? AW : CW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_GAP} state_t;

  state_t        r_state;
  logic [1:0]    r_target;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_remaining;
  logic [LW-1:0] r_lane;
  logic          r_cmd_ready;
  logic          r_s_ready;
  logic          r_write_mem1;
  logic          r_write_mem2;
  logic          r_simple_write;
  logic          r_busy;
  logic          r_cmd_done;
  logic          r_cmd_error;

  logic          w_cmd_take;
  logic          w_cmd_bad;
  logic          w_hs;
  logic          w_beat_last;
  logic [SW-1:0] w_cmd_end;

  // End address is computed one bit wider so an oversized command cannot wrap past the check.
  assign w_cmd_take  = i_cmd_valid && r_cmd_ready;
  assign w_cmd_end   = SW'(i_cmd_base_addr) + SW'(i_cmd_count);
  assign w_cmd_bad   = (i_cmd_count == '0) || (w_cmd_end > SW'(MEM_SIZE)) || (i_cmd_target == 2'd3);
  assign w_hs        = i_s_valid && r_s_ready;
  assign w_beat_last = w_hs && ((r_lane == LW'(NUM_UNITS - 1)) || (r_remaining == CW'(1)));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_target       <= '0;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_lane         <= '0;
      r_cmd_ready    <= 1'b1;
      r_s_ready      <= 1'b0;
      r_write_mem1   <= 1'b0;
      r_write_mem2   <= 1'b0;
      r_simple_write <= 1'b0;
      r_busy         <= 1'b0;
      r_cmd_done     <= 1'b0;
      r_cmd_error    <= 1'b0;
    end else begin
      r_cmd_done  <= 1'b0;
      r_cmd_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_take) begin
            if (w_cmd_bad) begin
              r_cmd_error <= 1'b1;
            end else begin
              r_state     <= S_FILL;
              r_target    <= i_cmd_target;
              r_addr      <= i_cmd_base_addr;
              r_remaining <= i_cmd_count;
              r_lane      <= '0;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_s_ready   <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_hs) begin
            r_addr      <= r_addr + AW'(1);
            r_remaining <= r_remaining - CW'(1);
            r_lane      <= r_lane + LW'(1);
            if (w_beat_last) begin
              r_state        <= S_WRITE;
              r_s_ready      <= 1'b0;
              r_write_mem1   <= (r_target == 2'd0);
              r_write_mem2   <= (r_target == 2'd1);
              r_simple_write <= (r_target == 2'd2);
            end
          end
        end
        S_WRITE: begin
          r_write_mem1   <= 1'b0;
          r_write_mem2   <= 1'b0;
          r_simple_write <= 1'b0;
          r_lane         <= '0;
          if (r_remaining != '0) begin
            r_state   <= S_FILL;
            r_s_ready <= 1'b1;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_cmd_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // On the closing handshake, lanes at or beyond the current one take the final word,
  // so a short last beat rewrites its last address instead of touching new ones.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_buf_data;
      logic [AW-1:0]         r_buf_addr;
      logic [DATA_WIDTH-1:0] r_out_data;
      logic [AW-1:0]         r_out_addr;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_buf_data <= '0;
          r_buf_addr <= '0;
          r_out_data <= '0;
          r_out_addr <= '0;
        end else begin
          if (w_hs && (r_lane == LW'(gi))) begin
            r_buf_data <= i_s_data;
            r_buf_addr <= r_addr;
          end
          if (w_beat_last) begin
            if (LW'(gi) < r_lane) begin
              r_out_data <= r_buf_data;
              r_out_addr <= r_buf_addr;
            end else begin
              r_out_data <= i_s_data;
              r_out_addr <= r_addr;
            end
          end
        end
      end

      assign o_data_in[gi*DATA_WIDTH +: DATA_WIDTH] = r_out_data;
      assign o_wr_addr[gi*AW +: AW]                 = r_out_addr;
    end
  endgenerate

  assign o_cmd_ready    = r_cmd_ready;
  assign o_s_ready      = r_s_ready;
  assign o_write_mem1   = r_write_mem1;
  assign o_write_mem2   = r_write_mem2;
  assign o_simple_write = r_simple_write;
  assign o_busy         = r_busy;
  assign o_cmd_done     = r_cmd_done;
  assign o_cmd_error    = r_cmd_error;
endmodule

// File: tb/tb_tpu_mem_loader.sv
// Self-checking bench for tpu_mem_loader: table vectors, hand sequences for reset
// and busy corner cases, and random commands against a beat-list reference model.
module tb_tpu_mem_loader;
  localparam int DW = 16;
  localparam int NU = 9;
  localparam int MS = 25;
  localparam int AW = 5;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_target;
  logic [AW-1:0]     cmd_base;
  logic [CW-1:0]     cmd_count;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic [NU*DW-1:0]  data_in;
  logic [NU*AW-1:0]  wr_addr;
  logic              wm1;
  logic              wm2;
  logic              swr;
  logic              busy;
  logic              cmd_done;
  logic              cmd_error;
  logic [2:0]        stb;

  always #5 clk = ~clk;

  tpu_mem_loader dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_target   (cmd_target),
    .i_cmd_base_addr(cmd_base),
    .i_cmd_count    (cmd_count),
    .i_s_valid      (s_valid),
    .o_s_ready      (s_ready),
    .i_s_data       (s_data),
    .o_data_in      (data_in),
    .o_wr_addr      (wr_addr),
    .o_write_mem1   (wm1),
    .o_write_mem2   (wm2),
    .o_simple_write (swr),
    .o_busy         (busy),
    .o_cmd_done     (cmd_done),
    .o_cmd_error    (cmd_error)
  );

  assign stb = {wm1, wm2, swr};

  typedef struct {
    logic [2:0]       stb;
    logic [NU*DW-1:0] d;
    logic [NU*AW-1:0] a;
    int               cyc;
  } beat_t;

  typedef struct {
    logic [1:0] tgt;
    int         base;
    int         count;
    int         bub;
    bit         poke;
    int         beats;
    bit         err;
  } vec_t;

  beat_t         beat_q[$];
  int            hs_q[$];
  logic [DW-1:0] words[MS];
  int            cyc = 0;
  int            done_cnt = 0;
  int            err_cnt = 0;
  int            sr_cnt = 0;
  int            overlap_cnt = 0;
  int            adj_cnt = 0;
  int            rb_cnt = 0;
  logic          prev_stb = 1'b0;
  int            total;
  int            bad;
  vec_t          vt[10];

  always @(posedge clk) cyc <= cyc + 1;

  // Observes the DUT mid-cycle and records every write beat and stream handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(stb) > 1) overlap_cnt <= overlap_cnt + 1;
      if ((stb != 3'b000) && prev_stb) adj_cnt <= adj_cnt + 1;
      prev_stb <= (stb != 3'b000);
      if (stb != 3'b000) beat_q.push_back('{stb, data_in, wr_addr, cyc});
      if (s_valid && s_ready) hs_q.push_back(cyc);
      if (s_ready) sr_cnt <= sr_cnt + 1;
      if (cmd_done) done_cnt <= done_cnt + 1;
      if (cmd_error) err_cnt <= err_cnt + 1;
      if (busy && cmd_ready) rb_cnt <= rb_cnt + 1;
    end else begin
      prev_stb <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl"}, 160'({cmd_ready, s_ready, wm1, wm2, swr, busy, cmd_done, cmd_error}), 160'(8'h80));
    check({tag, " data_in"}, 160'(data_in), 160'(0));
    check({tag, " wr_addr"}, 160'(wr_addr), 160'(0));
  endtask

  task automatic run_cmd(input int tgt, input int base, input int count, input int bub,
                         input bit poke, input bit legal);
    int idx;
    int guard;
    int done0;
    bit tog;
    bit hs;
    idx   = 0;
    guard = 0;
    tog   = 1'b1;
    done0 = done_cnt;
    beat_q.delete();
    hs_q.delete();
    cmd_valid  = 1'b1;
    cmd_target = 2'(tgt);
    cmd_base   = AW'(base);
    cmd_count  = CW'(count);
    @(negedge clk);
    check("cmd_ready idle", 160'(cmd_ready), 160'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (legal) begin
      while (idx < count && guard < 500) begin
        case (bub)
          0:       s_valid = 1'b1;
          1:       s_valid = tog;
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        tog    = ~tog;
        s_data = words[idx];
        if (poke && guard == 3) begin
          cmd_valid  = 1'b1;
          cmd_target = 2'd2;
          cmd_base   = '0;
          cmd_count  = CW'(1);
        end
        @(negedge clk);
        hs = s_valid && s_ready;
        if (poke && guard == 3) check("busy cmd_ready", 160'({busy, cmd_ready}), 160'(2'b10));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (hs) idx++;
        guard++;
      end
      s_valid = 1'b0;
      guard   = 0;
      while (done_cnt == done0 && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #1;
    end else begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  // Reference: beat b lane k carries word min(b*NU+k, count-1) at base plus that index.
  task automatic check_cmd(input string tag, input int tgt, input int base, input int count,
                           input int exp_beats, input bit exp_err, input int err0,
                           input int done0, input int sr0);
    logic [NU*DW-1:0] ed;
    logic [NU*AW-1:0] ea;
    logic [2:0]       es;
    int               idx;
    check($sformatf("%s err", tag), 160'(err_cnt - err0), 160'(exp_err));
    check($sformatf("%s done", tag), 160'(done_cnt - done0), 160'(exp_err ? 0 : 1));
    check($sformatf("%s beats", tag), 160'(beat_q.size()), 160'(exp_beats));
    if (exp_err) check($sformatf("%s s_ready", tag), 160'(sr_cnt - sr0), 160'(0));
    es = (tgt == 0) ? 3'b100 : (tgt == 1) ? 3'b010 : 3'b001;
    for (int b = 0; b < beat_q.size() && b < exp_beats; b++) begin
      for (int k = 0; k < NU; k++) begin
        idx = b * NU + k;
        if (idx > count - 1) idx = count - 1;
        ed[k*DW +: DW] = words[idx];
        ea[k*AW +: AW] = AW'(base + idx);
      end
      check($sformatf("%s beat%0d strobe", tag, b), 160'(beat_q[b].stb), 160'(es));
      check($sformatf("%s beat%0d data", tag, b), 160'(beat_q[b].d), 160'(ed));
      check($sformatf("%s beat%0d addr", tag, b), 160'(beat_q[b].a), 160'(ea));
      idx = b * NU + NU - 1;
      if (idx > count - 1) idx = count - 1;
      if (idx < hs_q.size())
        check($sformatf("%s beat%0d latency", tag, b), 160'(beat_q[b].cyc), 160'(hs_q[idx] + 1));
      else
        check($sformatf("%s beat%0d handshakes", tag, b), 160'(hs_q.size()), 160'(idx + 1));
    end
    $display("cmd %s tgt=%0d base=%0d count=%0d beats=%0d err=%0d", tag, tgt, base, count,
             beat_q.size(), err_cnt - err0);
  endtask

  task automatic do_cmd(input string tag, input int tgt, input int base, input int count,
                        input int bub, input bit poke, input int exp_beats, input bit exp_err);
    int err0;
    int done0;
    int sr0;
    err0  = err_cnt;
    done0 = done_cnt;
    sr0   = sr_cnt;
    run_cmd(tgt, base, count, bub, poke, !exp_err);
    check_cmd(tag, tgt, base, count, exp_beats, exp_err, err0, done0, sr0);
  endtask

  initial begin
    int t;
    int b;
    int c;
    bit ok;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_base   = '0;
    cmd_count  = '0;
    s_valid    = 1'b0;
    s_data     = '0;

    vt[0] = '{2'd0, 0, 25, 0, 1'b0, 3, 1'b0};
    vt[1] = '{2'd1, 0, 9, 1, 1'b0, 1, 1'b0};
    vt[2] = '{2'd2, 20, 5, 0, 1'b0, 1, 1'b0};
    vt[3] = '{2'd2, 20, 6, 0, 1'b0, 0, 1'b1};
    vt[4] = '{2'd0, 3, 0, 0, 1'b0, 0, 1'b1};
    vt[5] = '{2'd3, 0, 4, 0, 1'b0, 0, 1'b1};
    vt[6] = '{2'd1, 16, 9, 2, 1'b0, 1, 1'b0};
    vt[7] = '{2'd0, 24, 1, 0, 1'b0, 1, 1'b0};
    vt[8] = '{2'd2, 7, 10, 2, 1'b0, 2, 1'b0};
    vt[9] = '{2'd0, 2, 12, 0, 1'b1, 2, 1'b0};

    repeat (2) @(posedge clk);
    #4;
    check_reset_outputs("reset");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < MS; j++) words[j] = 16'h3C00 + 16'(j) + 16'(i * 16'h0100);
      do_cmd($sformatf("vec%0d", i), vt[i].tgt, vt[i].base, vt[i].count, vt[i].bub,
             vt[i].poke, vt[i].beats, vt[i].err);
      if (i == 0 && beat_q.size() == 3) begin
        check("vec0 beat spacing", 160'(beat_q[1].cyc - beat_q[0].cyc), 160'(NU + 1));
        check("vec0 data hold", 160'(data_in), 160'(beat_q[2].d));
        check("vec0 addr hold", 160'(wr_addr), 160'(beat_q[2].a));
      end
    end

    // Reset in the middle of filling the first beat, then a clean reload.
    beat_q.delete();
    c = done_cnt;
    cmd_valid  = 1'b1;
    cmd_target = 2'd0;
    cmd_base   = '0;
    cmd_count  = CW'(9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      s_valid = 1'b1;
      s_data  = 16'hA000 + 16'(j);
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-fill reset");
    s_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid-fill no beat", 160'(beat_q.size()), 160'(0));
    check("mid-fill no done", 160'(done_cnt - c), 160'(0));
    for (int j = 0; j < MS; j++) words[j] = 16'hB000 + 16'(j);
    do_cmd("after reset", 0, 0, 9, 0, 1'b0, 1, 1'b0);

    // Random commands, legal or not, judged purely from the command rules.
    for (int i = 0; i < 30; i++) begin
      t = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 24));
      c = int'($urandom_range(0, 12));
      ok = (c != 0) && (b + c <= MS) && (t != 3);
      for (int j = 0; j < MS; j++) words[j] = 16'($urandom);
      do_cmd($sformatf("rnd%0d", i), t, b, c, int'($urandom_range(0, 2)), 1'b0,
             ok ? (c + NU - 1) / NU : 0, !ok);
    end

    check("strobe overlap", 160'(overlap_cnt), 160'(0));
    check("adjacent strobes", 160'(adj_cnt), 160'(0));
    check("busy with cmd_ready", 160'(rb_cnt), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tpu_mem_loader.md
Name: tpu_mem_loader

Overview:
- Write-side initiator for the tensor_processing_unit parallel memory-load interface.
- Accepts a load command plus a serial valid/ready stream of DATA_WIDTH words, and packs them into NUM_UNITS-wide write beats.
- Drives data_in, a per-lane write address and exactly one of write_mem1 / write_mem2 / simple_write per beat.
- Replaces the hand-written per-beat load sequences currently used to fill image, kernel and simple memory before start.

Parameters:
- DATA_WIDTH, 16, word width (FP16).
- IMAGE_WIDTH, 5, image columns.
- IMAGE_HEIGHT, 5, image rows.
- NUM_UNITS, 9, lanes per write beat.
- MEM_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT, words per memory. Derived; do not override.
- Derived widths: AW = $clog2(MEM_SIZE) = 5; CW = $clog2(MEM_SIZE+1) = 5.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- cmd_valid, input, 1, load command valid.
- cmd_ready, output, 1, loader idle and able to take a command.
- cmd_target, input, 2, destination: 0 = mem1, 1 = mem2, 2 = simple, 3 = illegal.
- cmd_base_addr, input, AW, first word address.
- cmd_count, input, CW, number of words to load.
- s_valid, input, 1, stream word valid.
- s_ready, output, 1, loader accepts a stream word.
- s_data, input, DATA_WIDTH, stream word.
- data_in, output, NUM_UNITS x DATA_WIDTH, lane data to the TPU.
- wr_addr, output, NUM_UNITS x AW, lane addresses; fanned out to start_addr_1, start_addr_2 and simple_addr.
- write_mem1, output, 1, mem1 write strobe.
- write_mem2, output, 1, mem2 write strobe.
- simple_write, output, 1, simple memory write strobe.
- busy, output, 1, command in progress.
- cmd_done, output, 1, one-cycle pulse when a load completes.
- cmd_error, output, 1, one-cycle pulse when a command is rejected.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 except cmd_ready = 1. State = IDLE; lane buffers and counters cleared. Reset asserted mid-operation aborts immediately: strobes drop in the same cycle and no partial beat is issued.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch target, base and count.
  - Reject the command if count == 0, base + count > MEM_SIZE, or target == 3. On rejection: cmd_error = 1 for the next cycle, stay in IDLE.
  - Otherwise go to FILL with lane = 0, addr = base, remaining = count.
- FILL:
  - s_ready = 1.
  - Each s_valid && s_ready handshake stores s_data in lane[lane] and addr in waddr[lane], then increments lane and addr and decrements remaining.
  - Bubbles on s_valid are allowed; the loader waits indefinitely.
  - Go to WRITE when lane reaches NUM_UNITS or remaining reaches 0.
- WRITE (exactly one cycle):
  - The target strobe is high; s_ready = 0.
  - data_in and wr_addr are driven from registered lane buffers, stable the whole cycle.
  - Partial final beat: every unfilled lane repeats the last filled lane's data and address, so its write is idempotent. No out-of-range addresses and no zero overwrites occur.
  - If remaining > 0: go to FILL with lane = 0. Otherwise go to GAP.
- GAP (one cycle):
  - All strobes 0.
  - cmd_done = 1 in the following IDLE cycle.
- Strobes are mutually exclusive; at most one is high in any cycle. Strobes are registered outputs.
- Latency:
  - The first beat's strobe rises one cycle after the handshake that fills lane NUM_UNITS-1, or after the last word.
  - With continuous s_valid, one beat is issued every NUM_UNITS+1 cycles.
- busy = 1 from command acceptance through GAP.
- cmd_ready = 0 whenever busy. A cmd_valid seen while busy is ignored, with no error.
- data_in and wr_addr hold the last beat's values after the write until the next beat. This is harmless because strobes are low.
- No arithmetic on data. Address arithmetic is AW bits wide; the range check guarantees no wrap.

Test Plan:
1. Full 25-word load, continuous stream:
   - Stimulus: cmd target = 0, base = 0, count = 25; stream words 0..24 = the 5x5 image.
   - Required: write_mem1 high in exactly 3 separated cycles; beats carry addresses 0-8, 9-17 and 18-24.
   - Required: in beat 3, lanes 7 and 8 repeat address 24 and its data.
   - Required: cmd_done pulses once; write_mem2 and simple_write stay 0 throughout.
2. Kernel load with stream gaps:
   - Stimulus: target = 1, base = 0, count = 9; s_valid toggled 1,0,1,0...
   - Required: exactly one write_mem2 beat with addresses 0-8 in order; data matches the stream; no strobe before the 9th handshake.
3. Simple memory at an offset:
   - Stimulus: target = 2, base = 20, count = 5.
   - Required: one simple_write beat; lanes 0-4 carry addresses 20-24; lanes 5-8 repeat address 24.
4. Illegal commands:
   - Stimulus: (base = 20, count = 6), (count = 0) and (target = 3), each separately.
   - Required: cmd_error pulses once each; no strobe; no s_ready; cmd_ready stays 1.
5. Reset mid-fill:
   - Stimulus: assert reset after 5 of 9 words.
   - Required: outputs immediately return to reset values with no strobe; a new 9-word command then completes normally.
6. Command while busy:
   - Stimulus: cmd_valid pulsed during FILL.
   - Required: ignored; cmd_ready = 0; only the original load's beats appear.
